// File: rtl/exception_ctrl_if.sv
// Exception controller bus: MEM-stage event inputs, CP0 side outputs
// and the fetch redirect valid/ready handshake.
interface exception_ctrl_if;
    logic        i_mem_valid;
    logic [31:0] i_mem_pc;
    logic        i_mem_in_delay_slot;
    logic [5:0]  i_mem_exc;
    logic        i_mem_eret;
    logic [5:0]  i_int;
    logic        i_timer_int;
    logic [31:0] i_status_reg;
    logic [31:0] i_epc_reg;
    logic        i_redirect_ready;
    logic [4:0]  o_except_cause;
    logic [31:0] o_current_pc;
    logic        o_is_in_delay_slot;
    logic        o_is_eret;
    logic [5:0]  o_cp0_int;
    logic        o_flush;
    logic        o_busy;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    // Controller side
    modport slave (
        input  i_mem_valid,
        input  i_mem_pc,
        input  i_mem_in_delay_slot,
        input  i_mem_exc,
        input  i_mem_eret,
        input  i_int,
        input  i_timer_int,
        input  i_status_reg,
        input  i_epc_reg,
        input  i_redirect_ready,
        output o_except_cause,
        output o_current_pc,
        output o_is_in_delay_slot,
        output o_is_eret,
        output o_cp0_int,
        output o_flush,
        output o_busy,
        output o_redirect_valid,
        output o_redirect_pc
    );

    // Pipeline / CP0 / fetch side
    modport master (
        output i_mem_valid,
        output i_mem_pc,
        output i_mem_in_delay_slot,
        output i_mem_exc,
        output i_mem_eret,
        output i_int,
        output i_timer_int,
        output i_status_reg,
        output i_epc_reg,
        output i_redirect_ready,
        input  o_except_cause,
        input  o_current_pc,
        input  o_is_in_delay_slot,
        input  o_is_eret,
        input  o_cp0_int,
        input  o_flush,
        input  o_busy,
        input  o_redirect_valid,
        input  o_redirect_pc
    );
endinterface

// File: rtl/exception_ctrl.sv
// Exception controller: picks the highest-priority MEM-stage event,
// pulses CP0 for one cycle, flushes the pipe, then redirects fetch.
module exception_ctrl #(
    parameter logic [31:0] VEC_BEV  = 32'hBFC00380,
    parameter logic [31:0] VEC_NORM = 32'h80000180
) (
    input logic             clk,
    input logic             resetn,
    exception_ctrl_if.slave bus
);

    localparam logic [4:0] EXC_CAUSE_INT  = 5'd0;
    localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;
    localparam logic [4:0] EXC_CAUSE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CAUSE_BP   = 5'd9;
    localparam logic [4:0] EXC_CAUSE_RI   = 5'd10;
    localparam logic [4:0] EXC_CAUSE_OV   = 5'd12;
    localparam logic [4:0] EXC_CAUSE_NOP  = 5'h1F;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_FLUSH    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [5:0]  cp0_int;
    logic        int_pend;
    logic        ev_take;
    logic [4:0]  ev_cause;
    logic        ev_eret;
    logic        ev_fire;
    logic [4:0]  cause_q;
    logic [31:0] pc_q;
    logic        ds_q;
    logic        eret_q;
    logic [31:0] rpc_q;
    logic [31:0] st;
    logic        unused_status;

    assign st = bus.i_status_reg;

    // Only IE/EXL/IM/BEV are consulted here
    assign unused_status = ^{st[31:23], st[21:16], st[9:2]};

    // Timer interrupt shares hardware line 5
    always_comb begin
        cp0_int = {bus.i_int[5] | bus.i_timer_int, bus.i_int[4:0]};
    end

    assign bus.o_cp0_int = cp0_int;

    // Interrupt pending: enabled, not at exception level, unmasked line
    assign int_pend = st[0] & ~st[1] & (|(st[15:10] & cp0_int));

    // Event priority: interrupt, then synchronous faults, then ERET
    always_comb begin
        ev_take  = 1'b1;
        ev_cause = EXC_CAUSE_NOP;
        ev_eret  = 1'b0;
        if (int_pend) begin
            ev_cause = EXC_CAUSE_INT;
        end else if (bus.i_mem_exc[0]) begin
            ev_cause = EXC_CAUSE_ADEL;
        end else if (bus.i_mem_exc[1]) begin
            ev_cause = EXC_CAUSE_RI;
        end else if (bus.i_mem_exc[2]) begin
            ev_cause = EXC_CAUSE_OV;
        end else if (bus.i_mem_exc[3]) begin
            ev_cause = EXC_CAUSE_SYS;
        end else if (bus.i_mem_exc[4]) begin
            ev_cause = EXC_CAUSE_BP;
        end else if (bus.i_mem_exc[5]) begin
            ev_cause = EXC_CAUSE_ADES;
        end else if (bus.i_mem_eret) begin
            ev_eret = 1'b1;
        end else begin
            ev_take = 1'b0;
        end
    end

    // MEM inputs only matter while idle; FLUSH/REDIRECT ignore them
    assign ev_fire = (state == S_IDLE) & bus.i_mem_valid & ev_take;

    // Next-state selection for the IDLE -> FLUSH -> REDIRECT sequence
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ev_fire) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (bus.i_redirect_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // CP0 report: loaded on the event edge, cleared one cycle later
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cause_q <= EXC_CAUSE_NOP;
            pc_q    <= 32'd0;
            ds_q    <= 1'b0;
            eret_q  <= 1'b0;
        end else if (ev_fire) begin
            cause_q <= ev_cause;
            pc_q    <= bus.i_mem_pc;
            ds_q    <= bus.i_mem_in_delay_slot;
            eret_q  <= ev_eret;
        end else begin
            cause_q <= EXC_CAUSE_NOP;
            pc_q    <= 32'd0;
            ds_q    <= 1'b0;
            eret_q  <= 1'b0;
        end
    end

    // Redirect target: EPC for ERET, else vector chosen by BEV at FLUSH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rpc_q <= 32'd0;
        end else if (state == S_FLUSH) begin
            if (eret_q) begin
                rpc_q <= bus.i_epc_reg;
            end else if (st[22]) begin
                rpc_q <= VEC_BEV;
            end else begin
                rpc_q <= VEC_NORM;
            end
        end
    end

    assign bus.o_except_cause     = cause_q;
    assign bus.o_current_pc       = pc_q;
    assign bus.o_is_in_delay_slot = ds_q;
    assign bus.o_is_eret          = eret_q;
    assign bus.o_flush            = (state == S_FLUSH);
    assign bus.o_busy             = (state != S_IDLE);
    assign bus.o_redirect_valid   = (state == S_REDIRECT);
    assign bus.o_redirect_pc      = rpc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_exception_ctrl;

    localparam logic [4:0]  NOP  = 5'h1F;
    localparam logic [31:0] BEV  = 32'hBFC00380;
    localparam logic [31:0] NORM = 32'h80000180;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;
    bit   cmp_en;

    exception_ctrl_if bus();

    exception_ctrl #(
        .VEC_BEV (BEV),
        .VEC_NORM(NORM)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted event is a transaction that lives for one
    // flush cycle and then waits in redirect until fetch takes it.
    int          m_age;
    logic [4:0]  m_cause;
    logic [31:0] m_pc;
    logic        m_ds;
    logic        m_eret;
    logic [31:0] m_tgt;
    int          codes[6] = '{4, 10, 12, 8, 9, 5};

    always @(posedge clk or negedge resetn) begin
        logic [5:0]  line;
        logic [31:0] s;
        bit          hit;
        if (!resetn) begin
            m_age   = 0;
            m_cause = NOP;
            m_pc    = 0;
            m_ds    = 0;
            m_eret  = 0;
        end else if (m_age == 0) begin
            s    = bus.i_status_reg;
            line = {bus.i_int[5] | bus.i_timer_int, bus.i_int[4:0]};
            hit  = 0;
            m_eret = 0;
            if (bus.i_mem_valid) begin
                if (s[0] && !s[1] && ((s[15:10] & line) != 0)) begin
                    hit = 1;
                    m_cause = 5'd0;
                end else if (bus.i_mem_exc != 0) begin
                    hit = 1;
                    for (int b = 5; b >= 0; b--)
                        if (bus.i_mem_exc[b]) m_cause = 5'(codes[b]);
                end else if (bus.i_mem_eret) begin
                    hit = 1;
                    m_cause = NOP;
                    m_eret = 1;
                end
            end
            if (hit) begin
                m_pc  = bus.i_mem_pc;
                m_ds  = bus.i_mem_in_delay_slot;
                m_age = 1;
            end
        end else if (m_age == 1) begin
            if (m_eret) m_tgt = bus.i_epc_reg;
            else m_tgt = bus.i_status_reg[22] ? BEV : NORM;
            m_age = 2;
        end else if (bus.i_redirect_ready) begin
            m_age = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cp0_int", 32'(bus.o_cp0_int),
                32'({bus.i_int[5] | bus.i_timer_int, bus.i_int[4:0]}));
            chk("flush", 32'(bus.o_flush), 32'(m_age == 1));
            chk("busy", 32'(bus.o_busy), 32'(m_age != 0));
            chk("rvalid", 32'(bus.o_redirect_valid), 32'(m_age == 2));
            chk("cause", 32'(bus.o_except_cause),
                32'(m_age == 1 ? m_cause : NOP));
            chk("cur_pc", bus.o_current_pc, m_age == 1 ? m_pc : 32'd0);
            chk("ds", 32'(bus.o_is_in_delay_slot), 32'(m_age == 1 && m_ds));
            chk("eret", 32'(bus.o_is_eret), 32'(m_age == 1 && m_eret));
            if (m_age == 2) chk("rpc", bus.o_redirect_pc, m_tgt);
        end
    end

    task automatic idle_inputs();
        bus.i_mem_valid         = 0;
        bus.i_mem_pc            = 0;
        bus.i_mem_in_delay_slot = 0;
        bus.i_mem_exc           = 0;
        bus.i_mem_eret          = 0;
        bus.i_int               = 0;
        bus.i_timer_int         = 0;
        bus.i_status_reg        = 0;
        bus.i_epc_reg           = 0;
        bus.i_redirect_ready    = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one MEM instruction for one edge; return just after it
    task automatic fire(input logic [31:0] pc, input logic ds,
                        input logic [5:0] exc, input logic eret,
                        input logic [31:0] st);
        bus.i_mem_valid         = 1;
        bus.i_mem_pc            = pc;
        bus.i_mem_in_delay_slot = ds;
        bus.i_mem_exc           = exc;
        bus.i_mem_eret          = eret;
        bus.i_status_reg        = st;
        tick();
        bus.i_mem_valid = 0;
        bus.i_mem_exc   = 0;
        bus.i_mem_eret  = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cause"}, 32'(bus.o_except_cause), 32'(NOP));
        chk({tag, "_pc"}, bus.o_current_pc, 32'd0);
        chk({tag, "_ds"}, 32'(bus.o_is_in_delay_slot), 32'd0);
        chk({tag, "_eret"}, 32'(bus.o_is_eret), 32'd0);
        chk({tag, "_flush"}, 32'(bus.o_flush), 32'd0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
        chk({tag, "_rv"}, 32'(bus.o_redirect_valid), 32'd0);
        chk({tag, "_rpc"}, bus.o_redirect_pc, 32'd0);
    endtask

    logic [31:0] held;

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        cmp_en = 0;
        idle_inputs();
        resetn = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        resetn = 1;
        cmp_en = 1;
        tick();

        // Syscall with BEV set
        fire(32'h80001000, 0, 6'b001000, 0, 32'h00400000);
        chk("sys_cause", 32'(bus.o_except_cause), 32'd8);
        chk("sys_pc", bus.o_current_pc, 32'h80001000);
        chk("sys_flush", 32'(bus.o_flush), 32'd1);
        tick();
        chk("sys_flush_off", 32'(bus.o_flush), 32'd0);
        chk("sys_cause_off", 32'(bus.o_except_cause), 32'(NOP));
        chk("sys_rv", 32'(bus.o_redirect_valid), 32'd1);
        chk("sys_rpc", bus.o_redirect_pc, BEV);
        tick();
        chk("sys_idle", 32'(bus.o_busy), 32'd0);

        // Ov and AdEL together: AdEL wins
        fire(32'h80000400, 0, 6'b000101, 0, 32'h0);
        chk("pri_cause", 32'(bus.o_except_cause), 32'd4);
        tick();
        chk("pri_rpc", bus.o_redirect_pc, NORM);
        tick();

        // Timer interrupt in a delay slot
        bus.i_timer_int = 1;
        fire(32'h80000020, 1, 6'b0, 0, 32'h00008001);
        chk("tmr_cause", 32'(bus.o_except_cause), 32'd0);
        chk("tmr_ds", 32'(bus.o_is_in_delay_slot), 32'd1);
        tick();
        chk("tmr_rpc", bus.o_redirect_pc, NORM);
        tick();
        // Same interrupt with EXL set is not taken
        fire(32'h80000020, 1, 6'b0, 0, 32'h00008003);
        chk("tmr_exl_flush", 32'(bus.o_flush), 32'd0);
        chk("tmr_exl_busy", 32'(bus.o_busy), 32'd0);
        bus.i_timer_int = 0;
        tick();

        // ERET to EPC
        bus.i_epc_reg = 32'h80002004;
        fire(32'h80000500, 0, 6'b0, 1, 32'h0);
        chk("eret_pulse", 32'(bus.o_is_eret), 32'd1);
        chk("eret_cause", 32'(bus.o_except_cause), 32'(NOP));
        tick();
        chk("eret_pulse_off", 32'(bus.o_is_eret), 32'd0);
        chk("eret_rpc", bus.o_redirect_pc, 32'h80002004);
        tick();

        // Backpressure: redirect held while fetch is not ready
        bus.i_redirect_ready = 0;
        fire(32'h80003000, 0, 6'b001000, 0, 32'h00400000);
        tick();
        held = bus.o_redirect_pc;
        chk("bp_rpc0", held, BEV);
        for (int i = 0; i < 5; i++) begin
            bus.i_mem_valid  = (i < 3);
            bus.i_mem_exc    = 6'b001000;
            bus.i_status_reg = 32'h0;
            tick();
            chk("bp_rv", 32'(bus.o_redirect_valid), 32'd1);
            chk("bp_busy", 32'(bus.o_busy), 32'd1);
            chk("bp_rpc", bus.o_redirect_pc, held);
            chk("bp_flush", 32'(bus.o_flush), 32'd0);
        end
        bus.i_mem_valid      = 0;
        bus.i_mem_exc        = 0;
        bus.i_redirect_ready = 1;
        tick();
        chk("bp_idle", 32'(bus.o_busy), 32'd0);
        chk("bp_rv_off", 32'(bus.o_redirect_valid), 32'd0);

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] s;
            s = $urandom;
            s[0] = ($urandom_range(0, 3) != 0);
            s[1] = ($urandom_range(0, 4) == 0);
            bus.i_status_reg        = s;
            bus.i_mem_valid         = $urandom_range(0, 1);
            bus.i_mem_pc            = $urandom;
            bus.i_mem_in_delay_slot = $urandom_range(0, 1);
            bus.i_mem_exc           = '0;
            for (int b = 0; b < 6; b++)
                bus.i_mem_exc[b] = ($urandom_range(0, 9) == 0);
            bus.i_mem_eret       = ($urandom_range(0, 5) == 0);
            bus.i_int            = ($urandom_range(0, 5) == 0) ?
                                   6'($urandom) : 6'd0;
            bus.i_timer_int      = ($urandom_range(0, 7) == 0);
            bus.i_epc_reg        = $urandom;
            bus.i_redirect_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle_inputs();
        repeat (4) tick();

        // Reset in the middle of a redirect
        bus.i_redirect_ready = 0;
        fire(32'h80004000, 0, 6'b001000, 0, 32'h0);
        tick();
        chk("mid_rv", 32'(bus.o_redirect_valid), 32'd1);
        #2;
        resetn = 0;
        #1;
        chk_reset_vals("async");
        tick();
        resetn = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_rv", 32'(bus.o_redirect_valid), 32'd0);
        end
        bus.i_redirect_ready = 1;
        repeat (2) tick();

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have parameters: VEC_BEV, default 32'hBFC00380, vector used when Status[22]=1; VEC_NORM, default 32'h80000180, vector used when Status[22]=0.
REQ-002 SHALL have ports, one per line:
  clk  in  1  system clock; all state on the rising edge
  resetn  in  1  asynchronous active-low reset
  i_mem_valid  in  1  MEM-stage instruction valid
  i_mem_pc  in  32  MEM-stage PC
  i_mem_in_delay_slot  in  1  MEM instruction is in a delay slot
  i_mem_exc  in  6  flags {AdES,Bp,Sys,Ov,RI,AdEL}, bit0=AdEL
  i_mem_eret  in  1  MEM instruction is ERET
  i_int  in  6  external hardware interrupt lines
  i_timer_int  in  1  CP0 timer interrupt, ORed into int line 5
  i_status_reg  in  32  CP0 Status
  i_epc_reg  in  32  CP0 EPC
  i_redirect_ready  in  1  fetch accepts redirect
  o_except_cause  out  5  cause to CP0; EXC_CAUSE_NOP when idle
  o_current_pc  out  32  PC to CP0
  o_is_in_delay_slot  out  1  delay-slot flag to CP0
  o_is_eret  out  1  ERET pulse to CP0
  o_cp0_int  out  6  interrupt lines to CP0 i_int
  o_flush  out  1  kill IF..MEM
  o_busy  out  1  stall pipeline
  o_redirect_valid  out  1  redirect request
  o_redirect_pc  out  32  redirect target
REQ-003 SHALL use one clock (clk) and an asynchronous, active-low reset (resetn).

Function
REQ-004 SHALL drive o_cp0_int = {i_int[5] | i_timer_int, i_int[4:0]} combinationally.
REQ-005 SHALL compute int_pend = Status[0] & ~Status[1] & |(Status[15:10] & o_cp0_int).
REQ-006 SHALL have three states: IDLE, FLUSH, REDIRECT.
REQ-007 In IDLE with i_mem_valid=1, SHALL select the event by priority: interrupt > AdEL(4) > RI(10) > Ov(12) > Sys(8) > Bp(9) > AdES(5) > ERET; interrupt uses EXC_CAUSE_INT (code 0).
REQ-008 On a selected event, SHALL register o_except_cause (cause code, or EXC_CAUSE_NOP for ERET), o_current_pc=i_mem_pc, o_is_in_delay_slot, and o_is_eret (ERET only), and SHALL go to FLUSH.
REQ-009 The CP0 outputs SHALL be valid for exactly one cycle, the FLUSH cycle, and SHALL return to NOP/0 afterwards.
REQ-010 In FLUSH, o_flush=1 and o_busy=1 for one cycle; the target SHALL be latched: i_epc_reg for ERET, otherwise VEC_BEV or VEC_NORM per Status[22] sampled at FLUSH; the FSM SHALL then go to REDIRECT.
REQ-011 In REDIRECT, o_redirect_valid=1, o_busy=1, and o_redirect_pc SHALL be held stable until i_redirect_ready=1; the FSM SHALL then return to IDLE on that same edge.
REQ-012 A synchronous exception with Status[1]=1 SHALL still flush and redirect to the vector; the event SHALL not be dropped.
REQ-013 Latency SHALL be: event in IDLE at edge N, CP0 pulse and flush in N..N+1, o_redirect_valid from N+1; with i_redirect_ready held high, IDLE again at N+2.
REQ-014 With i_mem_valid=0, no event SHALL be taken; a pending interrupt SHALL wait for the next valid instruction.
REQ-015 In FLUSH and REDIRECT, all MEM inputs SHALL be ignored; no second event SHALL be queued.
REQ-016 o_busy SHALL be 0 in IDLE.

Reset
REQ-017 resetn=0 at any time SHALL immediately force IDLE, o_except_cause=EXC_CAUSE_NOP, o_current_pc=0, o_is_in_delay_slot=0, o_is_eret=0, o_flush=0, o_busy=0, o_redirect_valid=0, o_redirect_pc=0.
REQ-018 Reset during REDIRECT SHALL abandon the redirect; after reset, no redirect SHALL be asserted until a new event.

Verification
REQ-019 Sys: i_mem_exc=6'b001000, pc=32'h80001000, Status=32'h00400000 -> cause 8, o_current_pc=32'h80001000, o_flush one cycle, o_redirect_pc=32'hBFC00380.
REQ-020 Priority: Ov and AdEL together, Status[22]=0 -> cause 4, redirect 32'h80000180; Ov is never reported.
REQ-021 Timer interrupt: Status=32'h00008001, i_timer_int=1, valid pc=32'h80000020 in delay slot -> cause 0, o_is_in_delay_slot=1, redirect to vector; with Status[1]=1, no event.
REQ-022 ERET: i_mem_eret=1, i_epc_reg=32'h80002004 -> o_is_eret one-cycle pulse, cause NOP, o_redirect_pc=32'h80002004.
REQ-023 Backpressure: i_redirect_ready=0 for 5 cycles -> o_redirect_valid/o_redirect_pc stable, o_busy=1, new Sys input ignored; ready=1 -> IDLE next cycle.
REQ-024 resetn low mid-REDIRECT -> all outputs at reset values asynchronously; no redirect after release.
